// File: rtl/cpu_timer_pkg.sv
// Shared constants for the CPU timer block: divider geometry, default
// tap bits for the TF1/TF4 sources and the halt FSM state encoding.
package cpu_timer_pkg;

    localparam int unsigned DIV_W          = 15;
    localparam int unsigned KEEP_BITS      = 6;
    localparam int unsigned K_W            = 4;
    localparam int unsigned F1_BIT_DEFAULT = 13;
    localparam int unsigned F4_BIT_DEFAULT = 10;

    // Bit 0 marks "CPU clock stopped", bit 1 marks the wake cycle, so the
    // halted/wake outputs are plain flop bits of the state register.
    typedef logic [1:0] state_t;
    localparam state_t ST_RUN  = 2'b00;
    localparam state_t ST_HALT = 2'b01;
    localparam state_t ST_WAKE = 2'b11;

endpackage

// File: rtl/cpu_timer_if.sv
// Request/status bundle between the CPU core (master) and the timer (slave).
interface cpu_timer_if;
    import cpu_timer_pkg::*;

    logic             clk_en_32k;
    logic             reset_divider;
    logic             reset_divider_keep_6;
    logic             reset_gamma;
    logic             halt_req;
    logic [K_W-1:0]   input_k;

    logic [DIV_W-1:0] divider;
    logic             divider_4hz;
    logic             divider_32hz;
    logic             gamma;
    logic             sec_tick;
    logic             halted;
    logic             wake;
    logic [K_W-1:0]   k_sync;

    modport master (
        output clk_en_32k, reset_divider, reset_divider_keep_6, reset_gamma,
               halt_req, input_k,
        input  divider, divider_4hz, divider_32hz, gamma, sec_tick, halted,
               wake, k_sync
    );

    modport slave (
        input  clk_en_32k, reset_divider, reset_divider_keep_6, reset_gamma,
               halt_req, input_k,
        output divider, divider_4hz, divider_32hz, gamma, sec_tick, halted,
               wake, k_sync
    );

endinterface

// File: rtl/k_synchronizer.sv
// Two-flop synchronizer for the asynchronous K key lines.
module k_synchronizer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cpu_timer.sv
// CPU timer: free-running 15-bit divider, one-second gamma flag, K-line
// synchronizer and the halt/wake sequencer.
//
// state | meaning
// RUN   | CPU clock running, halt_req accepted
// HALT  | CPU clock stopped, waiting for a K key or a new gamma
// WAKE  | one-cycle wake pulse, CPU clock still stopped
module cpu_timer
    import cpu_timer_pkg::*;
#(
    parameter int unsigned F1_BIT = F1_BIT_DEFAULT,
    parameter int unsigned F4_BIT = F4_BIT_DEFAULT
) (
    input logic        clk,
    input logic        reset_n,
    cpu_timer_if.slave bus
);

    logic [DIV_W-1:0] divider_q;
    logic [DIV_W-1:0] divider_d;
    logic             wrap;
    logic             gamma_q;
    logic             gamma_prev;
    logic             gamma_rise;
    logic             sec_tick_q;
    state_t           state_q;
    state_t           state_d;
    logic [K_W-1:0]   k_sync;

    k_synchronizer #(.WIDTH(K_W)) u_k_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (bus.input_k),
        .q       (k_sync)
    );

    always_comb begin
        divider_d = divider_q;
        wrap      = 1'b0;
        if (bus.reset_divider) begin
            divider_d = '0;
        end else if (bus.reset_divider_keep_6) begin
            divider_d = {{(DIV_W-KEEP_BITS){1'b0}}, divider_q[KEEP_BITS-1:0]};
        end else if (bus.clk_en_32k) begin
            divider_d = divider_q + 1'b1;
            wrap      = (divider_q == '1);
        end
    end

    assign gamma_rise = gamma_q & ~gamma_prev;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (bus.halt_req) state_d = ST_HALT;
            ST_HALT: if ((|k_sync) || gamma_rise) state_d = ST_WAKE;
            ST_WAKE: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            divider_q  <= '0;
            gamma_q    <= 1'b0;
            gamma_prev <= 1'b0;
            sec_tick_q <= 1'b0;
            state_q    <= ST_RUN;
        end else begin
            divider_q  <= divider_d;
            sec_tick_q <= wrap;
            gamma_prev <= gamma_q;
            state_q    <= state_d;
            // A wrap outranks reset_gamma so a second boundary is never lost.
            if (wrap) begin
                gamma_q <= 1'b1;
            end else if (bus.reset_gamma) begin
                gamma_q <= 1'b0;
            end
        end
    end

    assign bus.divider      = divider_q;
    assign bus.divider_4hz  = divider_q[F1_BIT];
    assign bus.divider_32hz = divider_q[F4_BIT];
    assign bus.gamma        = gamma_q;
    assign bus.sec_tick     = sec_tick_q;
    assign bus.halted       = state_q[0];
    assign bus.wake         = state_q[1];
    assign bus.k_sync       = k_sync;

endmodule

// File: tb/tb_cpu_timer.sv
// Directed bench for cpu_timer: a per-cycle vector table plus hand-written
// sequences for wrap, keep-6, gamma collision, gamma wake and reset in halt.
module tb_cpu_timer;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    cpu_timer_if bus ();

    cpu_timer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // ctl = {clk_en_32k, reset_divider, reset_divider_keep_6, reset_gamma, halt_req}
    // st  = {gamma, sec_tick, halted, wake}
    typedef struct {
        logic [4:0]  ctl;
        logic [3:0]  k;
        logic [14:0] div;
        logic [3:0]  st;
        logic [3:0]  ks;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic set_vec(input int i, input logic [4:0] ctl, input logic [3:0] k,
                           input logic [14:0] div, input logic [3:0] st,
                           input logic [3:0] ks);
        vecs[i].ctl = ctl;
        vecs[i].k   = k;
        vecs[i].div = div;
        vecs[i].st  = st;
        vecs[i].ks  = ks;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] ctl, input logic [3:0] k);
        {bus.clk_en_32k, bus.reset_divider, bus.reset_divider_keep_6,
         bus.reset_gamma, bus.halt_req} = ctl;
        bus.input_k = k;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // {divider, gamma, sec_tick, halted, wake, k_sync}
    function automatic logic [31:0] obs();
        return 32'({bus.divider, bus.gamma, bus.sec_tick, bus.halted, bus.wake, bus.k_sync});
    endfunction

    function automatic logic [31:0] expv(input logic [14:0] div, input logic [3:0] st,
                                         input logic [3:0] ks);
        return 32'({div, st, ks});
    endfunction

    task automatic ticks(input int n);
        drive(5'b10000, 4'h0);
        repeat (n) step();
        drive(5'b00000, 4'h0);
    endtask

    task automatic do_reset();
        drive(5'b00000, 4'h0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        set_vec( 0, 5'b10000, 4'h0, 15'd1, 4'b0000, 4'h0);
        set_vec( 1, 5'b10000, 4'h0, 15'd2, 4'b0000, 4'h0);
        set_vec( 2, 5'b00000, 4'h0, 15'd2, 4'b0000, 4'h0);
        set_vec( 3, 5'b11000, 4'h0, 15'd0, 4'b0000, 4'h0);
        set_vec( 4, 5'b10000, 4'h0, 15'd1, 4'b0000, 4'h0);
        set_vec( 5, 5'b10000, 4'h0, 15'd2, 4'b0000, 4'h0);
        set_vec( 6, 5'b10100, 4'h0, 15'd2, 4'b0000, 4'h0);
        set_vec( 7, 5'b10010, 4'h0, 15'd3, 4'b0000, 4'h0);
        set_vec( 8, 5'b00001, 4'h0, 15'd3, 4'b0010, 4'h0);
        set_vec( 9, 5'b00000, 4'h0, 15'd3, 4'b0010, 4'h0);
        set_vec(10, 5'b10000, 4'h0, 15'd4, 4'b0010, 4'h0);
        set_vec(11, 5'b00000, 4'h1, 15'd4, 4'b0010, 4'h0);
        set_vec(12, 5'b00000, 4'h1, 15'd4, 4'b0010, 4'h1);
        set_vec(13, 5'b00001, 4'h0, 15'd4, 4'b0011, 4'h1);
        set_vec(14, 5'b00000, 4'h0, 15'd4, 4'b0000, 4'h0);
        set_vec(15, 5'b10001, 4'h0, 15'd5, 4'b0010, 4'h0);
        set_vec(16, 5'b00000, 4'h0, 15'd5, 4'b0010, 4'h0);

        reset_n = 1'b0;
        drive(5'b00000, 4'h0);
        @(negedge clk);
        check("reset_state", obs(), expv(15'd0, 4'b0000, 4'h0));
        reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].ctl, vecs[i].k);
            step();
            check($sformatf("vec%0d", i), obs(), expv(vecs[i].div, vecs[i].st, vecs[i].ks));
        end

        // Reset while halted with a key press in the synchronizer.
        drive(5'b00000, 4'b0100);
        step();
        reset_n = 1'b0;
        drive(5'b00000, 4'h0);
        #1;
        check("reset_in_halt", obs(), expv(15'd0, 4'b0000, 4'h0));
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("post_reset_idle%0d", i), 32'({bus.halted, bus.wake}), 32'd0);
        end

        // Keep-6 clear.
        do_reset();
        ticks(6844);
        check("div_1abc", 32'(bus.divider), 32'h1ABC);
        drive(5'b10100, 4'h0);
        step();
        check("keep6", 32'(bus.divider), 32'h003C);

        // Wrap, gamma collision, reset_divider leaves gamma alone.
        do_reset();
        ticks(32766);
        check("div_7ffe", 32'(bus.divider), 32'h7FFE);
        check("taps_7ffe", 32'({bus.divider_4hz, bus.divider_32hz}), 32'b11);
        drive(5'b10000, 4'h0);
        step();
        check("div_7fff", obs(), expv(15'h7FFF, 4'b0000, 4'h0));
        drive(5'b10010, 4'h0);
        step();
        check("wrap_collision", obs(), expv(15'h0000, 4'b1100, 4'h0));
        check("taps_0", 32'({bus.divider_4hz, bus.divider_32hz}), 32'b00);
        drive(5'b01000, 4'h0);
        step();
        check("rdiv_keeps_gamma", obs(), expv(15'h0000, 4'b1000, 4'h0));
        drive(5'b00010, 4'h0);
        step();
        check("gamma_cleared", obs(), expv(15'h0000, 4'b0000, 4'h0));

        // Gamma rising edge wakes a halted CPU; divider keeps counting in HALT.
        do_reset();
        ticks(32767);
        check("div_7fff_b", 32'(bus.divider), 32'h7FFF);
        drive(5'b00001, 4'h0);
        step();
        check("halt_b", obs(), expv(15'h7FFF, 4'b0010, 4'h0));
        drive(5'b10000, 4'h0);
        step();
        check("wrap_in_halt", obs(), expv(15'h0000, 4'b1110, 4'h0));
        drive(5'b00000, 4'h0);
        step();
        check("gamma_wake", obs(), expv(15'h0000, 4'b1011, 4'h0));
        step();
        check("back_to_run", obs(), expv(15'h0000, 4'b1000, 4'h0));
        drive(5'b00001, 4'h0);
        step();
        drive(5'b00000, 4'h0);
        step();
        step();
        check("gamma_level_no_wake", obs(), expv(15'h0000, 4'b1010, 4'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_timer.md
CPU_TIMER -- requirements
Module: cpu_timer

Interface
REQ-001 SHALL have parameter F1_BIT, default 13: divider bit driven on divider_4hz (TF1 source).
REQ-002 SHALL have parameter F4_BIT, default 10: divider bit driven on divider_32hz (TF4 source).
REQ-003 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port clk_en_32k  input  1  one-cycle pulse at 32.768 kHz rate; the divider advances only on it.
REQ-006 SHALL have port reset_divider  input  1  IDIV/CEND request: clear the whole divider.
REQ-007 SHALL have port reset_divider_keep_6  input  1  SM500-family IDIV: clear divider[14:6] and keep divider[5:0].
REQ-008 SHALL have port reset_gamma  input  1  TIS request: clear gamma.
REQ-009 SHALL have port halt_req  input  1  CEND: enter halt.
REQ-010 SHALL have port input_k  input  4  asynchronous K key lines.
REQ-011 SHALL have port divider  output  15  clock divider value.
REQ-012 SHALL have port divider_4hz / divider_32hz  output  1 each  divider[F1_BIT] / divider[F4_BIT].
REQ-013 SHALL have port gamma  output  1  one-second flag.
REQ-014 SHALL have port sec_tick  output  1  one-cycle pulse on divider wrap.
REQ-015 SHALL have port halted  output  1  high while the CPU clock is stopped.
REQ-016 SHALL have port wake  output  1  one-cycle pulse on leaving halt.
REQ-017 SHALL have port k_sync  output  4  synchronized input_k.

Function
REQ-018 SHALL increment divider by 1, modulo 2^15, on each clk_en_32k cycle that has no reset request.
REQ-019 SHALL apply divider priority reset_divider > reset_divider_keep_6 > increment, each taking effect on the next edge.
REQ-020 SHALL, for keep_6, zero bits [14:6] and leave bits [5:0] unchanged that cycle, with no increment even if clk_en_32k is high.
REQ-021 SHALL, on increment from 0x7FFF to 0x0000, set gamma and pulse sec_tick on the same edge.
REQ-022 SHALL let a gamma set win over a simultaneous reset_gamma, so a wrap event is never lost.
REQ-023 SHALL hold gamma set until reset_gamma or reset; reset_divider SHALL NOT clear gamma.
REQ-024 SHALL keep the divider counting in every FSM state.
REQ-025 SHALL synchronize input_k through 2 flops before any use (2-cycle latency).
REQ-026 SHALL implement the FSM as follows: RUN -> HALT when halt_req is high; HALT -> WAKE when any k_sync bit is high, or on a gamma 0->1 transition; WAKE -> RUN unconditionally after 1 cycle.
REQ-027 SHALL drive halted=1 in HALT and WAKE, and wake=1 only in WAKE.
REQ-028 SHALL ignore halt_req outside RUN.
REQ-029 SHALL treat a wake condition present on the HALT entry cycle as taking effect next cycle, giving a minimum HALT duration of 1 cycle.
REQ-030 SHALL register all outputs; divider_4hz, divider_32hz and sec_tick SHALL track the registered divider with no extra latency.

Reset
REQ-031 SHALL, on reset_n low, immediately set divider=0, gamma=0, sec_tick=0, halted=0, wake=0, k_sync=0, and FSM=RUN.
REQ-032 SHALL abort a halt or wake in progress on reset mid-operation and resume in RUN with no wake pulse.
REQ-033 SHALL begin counting on the first clk_en_32k after reset_n is released.

Structure
REQ-034 SHALL place the FSM state enum (RUN, HALT, WAKE) and the default F1_BIT/F4_BIT constants in the shared CPU package.
REQ-035 SHALL implement the 2-flop K synchronizer as the sub-module k_synchronizer, instantiated once for 4 bits.

Verification
REQ-036 Wrap: preload divider to 0x7FFE via ticks, then apply 2 clk_en_32k -> divider 0x0000, gamma=1, sec_tick high 1 cycle.
REQ-037 Keep-6: with divider=0x1ABC, pulse reset_divider_keep_6 and clk_en_32k together -> divider=0x003C next edge.
REQ-038 Collision: wrap and reset_gamma on the same cycle -> gamma=1; reset_gamma alone next cycle -> gamma=0.
REQ-039 Halt/wake: halt_req in RUN -> halted=1; input_k=4'b0010 -> wake pulses 3 cycles later (2 sync + 1), then RUN with halted=0.
REQ-040 Reset mid-halt: assert reset_n low in HALT -> halted=0, divider=0, no wake pulse after release.
